// File: rtl/mest_pro_pkg.sv
// mest_pro_pkg: shared types for the mest_pro result buffer
package mest_pro_pkg;
    localparam int RB_DATA_WIDTH = 8;
    typedef enum logic [1:0] {RB_IDLE, RB_RUN, RB_FLUSH, RB_DONE} rb_state_t;
    typedef struct packed {
        logic                     zero;
        logic                     carry;
        logic [RB_DATA_WIDTH-1:0] result;
    } rb_entry_t;
endpackage

// File: rtl/mest_pro_sync_fifo.sv
// mest_pro_sync_fifo: first-word-fall-through FIFO with synchronous flush
module mest_pro_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mest_pro_result_buffer.sv
// mest_pro_result_buffer: captures core results into a FWFT FIFO, drains them, keeps run statistics
module mest_pro_result_buffer
    import mest_pro_pkg::*;
#(
    parameter int DATA_WIDTH = RB_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          i_reset_n,
    input  logic                          i_start,
    input  logic [DATA_WIDTH-1:0]         i_result,
    input  logic                          i_valid_result,
    input  logic                          i_carry,
    input  logic                          i_zero_flag,
    input  logic                          i_all_done,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_carry,
    output logic                          o_zero,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic [CNT_WIDTH-1:0]          o_result_cnt,
    output logic [CNT_WIDTH-1:0]          o_carry_cnt,
    output logic [CNT_WIDTH-1:0]          o_zero_cnt,
    output logic                          o_drained
);
    rb_state_t state;
    rb_entry_t wr_entry, head;
    logic full, empty, pop, push_req, accept, drop;
    assign wr_entry = '{zero: i_zero_flag, carry: i_carry, result: i_result};
    assign o_valid  = ~empty;
    assign o_data   = head.result;
    assign o_carry  = head.carry;
    assign o_zero   = head.zero;
    assign pop      = o_valid & i_ready;
    // RUN includes the cycle i_all_done arrives; a strobe alongside i_start belongs to the old run
    assign push_req = i_valid_result & (state == RB_RUN) & ~i_start;
    assign accept   = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    mest_pro_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(rb_entry_t))) u_fifo (
        .clk   (clk),
        .rst_n (i_reset_n),
        .flush (i_start),
        .push  (push_req),
        .pop   (pop),
        .din   (wr_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (o_level)
    );
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= RB_IDLE;
            o_drained    <= 1'b0;
            o_overflow   <= 1'b0;
            o_result_cnt <= '0;
            o_carry_cnt  <= '0;
            o_zero_cnt   <= '0;
        end else if (i_start) begin
            state        <= RB_RUN;
            o_drained    <= 1'b0;
            o_overflow   <= 1'b0;
            o_result_cnt <= '0;
            o_carry_cnt  <= '0;
            o_zero_cnt   <= '0;
        end else begin
            if (state == RB_RUN && i_all_done) state <= RB_FLUSH;
            if (state == RB_FLUSH && o_level == '0) begin
                state     <= RB_DONE;
                o_drained <= 1'b1;
            end
            if (drop) o_overflow <= 1'b1;
            if (accept) begin
                o_result_cnt <= o_result_cnt + CNT_WIDTH'(~&o_result_cnt);
                o_carry_cnt  <= o_carry_cnt + CNT_WIDTH'(i_carry && ~&o_carry_cnt);
                o_zero_cnt   <= o_zero_cnt + CNT_WIDTH'(i_zero_flag && ~&o_zero_cnt);
            end
        end
    end
endmodule

// File: tb/tb_mest_pro_result_buffer.sv
// tb_mest_pro_result_buffer: directed self-checking bench for the result buffer
module tb_mest_pro_result_buffer;
    logic       clk = 0;
    logic       i_reset_n = 0;
    logic       i_start = 0;
    logic [7:0] i_result = 0;
    logic       i_valid_result = 0;
    logic       i_carry = 0;
    logic       i_zero_flag = 0;
    logic       i_all_done = 0;
    logic       i_ready = 0;
    logic [7:0] o_data;
    logic       o_carry, o_zero, o_valid, o_overflow, o_drained;
    logic [4:0] o_level;
    logic [15:0] o_result_cnt, o_carry_cnt, o_zero_cnt;
    int n_cmp = 0;
    int n_bad = 0;

    mest_pro_result_buffer dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_result(i_result),
        .i_valid_result(i_valid_result), .i_carry(i_carry), .i_zero_flag(i_zero_flag),
        .i_all_done(i_all_done), .o_data(o_data), .o_carry(o_carry), .o_zero(o_zero),
        .o_valid(o_valid), .i_ready(i_ready), .o_level(o_level), .o_overflow(o_overflow),
        .o_result_cnt(o_result_cnt), .o_carry_cnt(o_carry_cnt), .o_zero_cnt(o_zero_cnt),
        .o_drained(o_drained)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic c, input logic z);
        i_valid_result = 1; i_result = d; i_carry = c; i_zero_flag = z;
        step();
        i_valid_result = 0; i_carry = 0; i_zero_flag = 0;
    endtask

    task automatic start();
        i_start = 1;
        step();
        i_start = 0;
    endtask

    initial begin
        step();
        check("rst_valid", o_valid, 0);
        check("rst_level", o_level, 0);
        check("rst_drained", o_drained, 0);
        check("rst_data", o_data, 0);
        i_reset_n = 1;
        step();
        // 1: reset mid-run
        start();
        for (int k = 0; k < 3; k++) push(8'(k + 1), 1, 1);
        check("t1_level_pre", o_level, 3);
        i_reset_n = 0;
        step();
        check("t1_valid", o_valid, 0);
        check("t1_level", o_level, 0);
        check("t1_rcnt", o_result_cnt, 0);
        check("t1_ccnt", o_carry_cnt, 0);
        check("t1_ovf", o_overflow, 0);
        i_reset_n = 1;
        step();
        // 2: stream order and flags
        start();
        i_ready = 1;
        push(8'h05, 0, 0);
        check("t2_d0", {o_valid, o_carry, o_zero, o_data}, {3'b100, 8'h05});
        push(8'hFF, 1, 0);
        check("t2_d1", {o_valid, o_carry, o_zero, o_data}, {3'b110, 8'hFF});
        push(8'h00, 0, 1);
        check("t2_d2", {o_valid, o_carry, o_zero, o_data}, {3'b101, 8'h00});
        step();
        check("t2_empty", o_valid, 0);
        check("t2_cnts", {o_result_cnt, o_carry_cnt, o_zero_cnt}, {16'd3, 16'd1, 16'd1});
        // 3: overflow drops the 17th value
        i_ready = 0;
        start();
        check("t3_clr", o_result_cnt, 0);
        for (int k = 0; k < 17; k++) push(8'(k), 0, 0);
        check("t3_level", o_level, 16);
        check("t3_ovf", o_overflow, 1);
        check("t3_rcnt", o_result_cnt, 16);
        i_ready = 1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t3_drain%0d", k), {o_valid, o_data}, {1'b1, 8'(k)});
            step();
        end
        check("t3_empty", o_valid, 0);
        // 4: push while full with simultaneous pop
        i_ready = 0;
        start();
        check("t4_ovf_clr", o_overflow, 0);
        for (int k = 0; k < 16; k++) push(8'(8'h20 + k), 0, 0);
        check("t4_full", o_level, 16);
        i_ready = 1;
        push(8'hAA, 0, 0);
        i_ready = 0;
        check("t4_level", o_level, 16);
        check("t4_ovf", o_overflow, 0);
        check("t4_rcnt", o_result_cnt, 17);
        check("t4_head", o_data, 8'h21);
        // 5: all_done window and drain completion
        start();
        for (int k = 0; k < 4; k++) push(8'(8'h40 + k), 0, 0);
        i_all_done = 1;
        push(8'h44, 0, 0);
        i_all_done = 0;
        push(8'h55, 0, 0);
        check("t5_level", o_level, 5);
        check("t5_rcnt", o_result_cnt, 5);
        i_ready = 1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t5_pop%0d", k), o_data, 8'(8'h40 + k));
            check($sformatf("t5_drn%0d", k), o_drained, 0);
            step();
        end
        check("t5_drn_lag", o_drained, 0);
        step();
        check("t5_drained", o_drained, 1);
        i_ready = 0;
        // 6: restart during FLUSH
        start();
        check("t6_drn_clr", o_drained, 0);
        push(8'h61, 1, 0);
        push(8'h62, 0, 0);
        i_all_done = 1;
        step();
        i_all_done = 0;
        step();
        check("t6_level_pre", o_level, 2);
        start();
        check("t6_valid", o_valid, 0);
        check("t6_level", o_level, 0);
        check("t6_cnts", {o_result_cnt, o_carry_cnt}, 0);
        check("t6_drained", o_drained, 0);
        push(8'h66, 0, 0);
        check("t6_run", {o_valid, o_data}, {1'b1, 8'h66});
        check("t6_rcnt", o_result_cnt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
